// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer:
// opcode constants, FSM states, trap causes and datapath mux selects.
package multicycle_ctrl_fsm_pkg;

  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_U_LUI   = 7'b0110111;
  localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_J_JAL   = 7'b1101111;
  localparam logic [6:0] OP_I_JALR  = 7'b1100111;

  // Wide enough for the largest supported MAX_WAIT (65535).
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } trap_cause_e;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4  = 2'd0,
    PC_SRC_TARGET = 2'd1,
    PC_SRC_JALR   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2
  } wb_sel_e;

  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_R, OP_I_ARITH, OP_I_LOAD, OP_S, OP_B,
      OP_U_LUI, OP_U_AUIPC, OP_J_JAL, OP_I_JALR: legal = 1'b1;
      default:                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_wait_watchdog.sv
// Wait-cycle counter shared by the FETCH and MEM phases; flags a timeout when
// the request has waited MAX_WAIT cycles and ready is still low.
module mem_wait_watchdog
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  // Outside a waiting phase, or once ready arrives, the count returns to zero,
  // so every fresh entry into FETCH or MEM starts counting from zero.
  always_comb begin
    wait_cnt_d = '0;
    if (active && !ready && (wait_cnt_q != LIMIT)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Ready on the limit cycle wins over the timeout.
  assign timeout = active && !ready && (wait_cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: walks each instruction through FETCH, DECODE,
// EXEC, MEM and WB and drives the datapath enables for each phase.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       dbg_state
);

  // Handshake: a request (imem_req / dmem_req) is held high every cycle until
  // the matching ready is sampled high on a rising clk edge; that cycle
  // completes the transfer. There is no separate valid: ready alone ends it.

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_cnt_q, retired_cnt_d;
  logic               trap_q, trap_d;
  trap_cause_e        trap_cause_q, trap_cause_d;

  logic               imem_req_c;
  logic               ir_write_c;
  logic               pc_write_c;
  pc_src_e            pc_src_c;
  logic               dmem_req_c;
  logic               dmem_we_c;
  logic               reg_write_c;
  wb_sel_e            wb_sel_c;
  logic               retire_c;

  logic               wd_active;
  logic               wd_ready;
  logic               wd_timeout;
  logic               is_store;

  assign is_store  = (opcode == OP_S);
  assign wd_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wd_ready  = (state_q == ST_FETCH) ? imem_ready : dmem_ready;

  mem_wait_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .active  (wd_active),
    .ready   (wd_ready),
    .timeout (wd_timeout)
  );

  always_comb begin
    state_d      = state_q;
    trap_d       = trap_q;
    trap_cause_d = trap_cause_q;
    imem_req_c   = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = PC_SRC_PLUS4;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    reg_write_c  = 1'b0;
    wb_sel_c     = WB_SEL_ALU;
    retire_c     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = ST_DECODE;
        end else if (wd_timeout) begin
          state_d      = ST_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_IMEM_TO;
        end
      end

      ST_DECODE: begin
        if (is_legal_op(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d      = ST_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_ILLEGAL;
        end
      end

      ST_EXEC: begin
        case (opcode)
          OP_I_LOAD, OP_S: state_d = ST_MEM;
          OP_B: begin
            // Branches finish here: no register write-back.
            pc_write_c = branch_taken;
            pc_src_c   = PC_SRC_TARGET;
            retire_c   = 1'b1;
            state_d    = ST_FETCH;
          end
          OP_J_JAL: begin
            pc_write_c = 1'b1;
            pc_src_c   = PC_SRC_TARGET;
            state_d    = ST_WB;
          end
          OP_I_JALR: begin
            pc_write_c = 1'b1;
            pc_src_c   = PC_SRC_JALR;
            state_d    = ST_WB;
          end
          default: state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_WB;
          end
        end else if (wd_timeout) begin
          state_d      = ST_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_DMEM_TO;
        end
      end

      ST_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = ST_FETCH;
        if (opcode == OP_I_LOAD) begin
          wb_sel_c = WB_SEL_MEM;
        end else if ((opcode == OP_J_JAL) || (opcode == OP_I_JALR)) begin
          wb_sel_c = WB_SEL_PC4;
        end
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (retire_c) begin
      retired_cnt_d = retired_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      retired_cnt_q <= '0;
      trap_q        <= 1'b0;
      trap_cause_q  <= CAUSE_NONE;
    end else begin
      state_q       <= state_d;
      retired_cnt_q <= retired_cnt_d;
      trap_q        <= trap_d;
      trap_cause_q  <= trap_cause_d;
    end
  end

  // Decoded enables are forced low while reset is held, since FETCH would
  // otherwise raise imem_req during reset.
  assign imem_req    = imem_req_c  & ~reset;
  assign ir_write    = ir_write_c  & ~reset;
  assign pc_write    = pc_write_c  & ~reset;
  assign pc_src      = reset ? 2'd0 : pc_src_c;
  assign dmem_req    = dmem_req_c  & ~reset;
  assign dmem_we     = dmem_we_c   & ~reset;
  assign reg_write   = reg_write_c & ~reset;
  assign wb_sel      = reset ? 2'd0 : wb_sel_c;
  assign retire      = retire_c    & ~reset;
  assign retired_cnt = retired_cnt_q;
  assign trap        = trap_q;
  assign trap_cause  = trap_cause_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm (MAX_WAIT=4, CNT_W=4): phase sequences,
// enables, wait handling, watchdog traps, counter wrap and asynchronous reset.
module tb_multicycle_ctrl_fsm;
  import multicycle_ctrl_fsm_pkg::*;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned OUT_W    = 14 + CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       opcode = OP_R;
  logic             branch_taken = 1'b0;
  logic             imem_ready = 1'b1;
  logic             dmem_ready = 1'b1;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [2:0]       dbg_state;
  logic [OUT_W-1:0] all_outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .retired_cnt  (retired_cnt),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .dbg_state    (dbg_state)
  );

  assign all_outs = {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we,
                     reg_write, wb_sel, retire, retired_cnt, trap, trap_cause};

  // Tasks start and end just after a rising edge; outputs are read at the
  // following falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_outs: got %h want 0", all_outs);
    end
    total++;
    if (dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_imem_req: got %b want 1", imem_req);
    end
  endtask

  task automatic test_add();
    int exp_st[4];
    exp_st = '{0, 1, 2, 4};
    opcode = OP_R; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (dbg_state !== 3'(exp_st[i])) begin
        bad++;
        $display("FAIL add_state c%0d: got %0d want %0d", i, dbg_state, exp_st[i]);
      end
      if (i == 0) begin
        total++;
        if ({imem_req, ir_write, pc_write, pc_src} !== 5'b11100) begin
          bad++;
          $display("FAIL add_fetch: got %b want 11100", {imem_req, ir_write, pc_write, pc_src});
        end
      end
      if (i == 3) begin
        total++;
        if ({reg_write, wb_sel, retire, dmem_we} !== 5'b10010) begin
          bad++;
          $display("FAIL add_wb: got %b want 10010", {reg_write, wb_sel, retire, dmem_we});
        end
      end
      next_cycle();
    end
    total++;
    if ({dbg_state, retired_cnt} !== {3'd0, 4'd1}) begin
      bad++;
      $display("FAIL add_end: state %0d cnt %0d want 0 1", dbg_state, retired_cnt);
    end
  endtask

  task automatic test_load_wait();
    int exp_st[8];
    int req_n = 0;
    int we_n = 0;
    exp_st = '{0, 1, 2, 3, 3, 3, 3, 4};
    opcode = OP_I_LOAD; imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dmem_ready = (i == 6);
      @(negedge clk);
      total++;
      if (dbg_state !== 3'(exp_st[i])) begin
        bad++;
        $display("FAIL lw_state c%0d: got %0d want %0d", i, dbg_state, exp_st[i]);
      end
      total++;
      if ((imem_req && dmem_req) || (reg_write && dmem_we)) begin
        bad++;
        $display("FAIL lw_exclusive c%0d: got %b want no overlap", i, {imem_req, dmem_req, reg_write, dmem_we});
      end
      if (dmem_req) req_n++;
      if (dmem_we) we_n++;
      if (i == 7) begin
        total++;
        if ({reg_write, wb_sel, retire} !== 4'b1011) begin
          bad++;
          $display("FAIL lw_wb: got %b want 1011", {reg_write, wb_sel, retire});
        end
      end
      next_cycle();
    end
    dmem_ready = 1'b1;
    total++;
    if (req_n != 4 || we_n != 0) begin
      bad++;
      $display("FAIL lw_dmem: req %0d we %0d want 4 0", req_n, we_n);
    end
    total++;
    if ({dbg_state, retired_cnt} !== {3'd0, 4'd2}) begin
      bad++;
      $display("FAIL lw_end: state %0d cnt %0d want 0 2", dbg_state, retired_cnt);
    end
  endtask

  task automatic test_branch();
    int rw_n = 0;
    logic taken;
    for (int t = 0; t < 2; t++) begin
      taken = (t == 0);
      opcode = OP_B; branch_taken = taken;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        total++;
        if (dbg_state !== 3'(i)) begin
          bad++;
          $display("FAIL br_state t%0d c%0d: got %0d want %0d", t, i, dbg_state, i);
        end
        if (reg_write) rw_n++;
        if (i == 2) begin
          total++;
          if ({pc_write, pc_src, retire} !== {taken, 2'b01, 1'b1}) begin
            bad++;
            $display("FAIL br_exec t%0d: got %b want %b", t, {pc_write, pc_src, retire}, {taken, 2'b01, 1'b1});
          end
        end
        next_cycle();
      end
      total++;
      if ({dbg_state, retired_cnt} !== {3'd0, 4'(3 + t)}) begin
        bad++;
        $display("FAIL br_end t%0d: state %0d cnt %0d want 0 %0d", t, dbg_state, retired_cnt, 3 + t);
      end
    end
    branch_taken = 1'b0;
    total++;
    if (rw_n != 0) begin
      bad++;
      $display("FAIL br_reg_write: got %0d cycles want 0", rw_n);
    end
  endtask

  task automatic test_jump();
    logic [1:0] exp_src;
    int exp_st[4];
    exp_st = '{0, 1, 2, 4};
    for (int t = 0; t < 2; t++) begin
      opcode  = (t == 0) ? OP_J_JAL : OP_I_JALR;
      exp_src = (t == 0) ? 2'd1 : 2'd2;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        total++;
        if (dbg_state !== 3'(exp_st[i])) begin
          bad++;
          $display("FAIL jmp_state t%0d c%0d: got %0d want %0d", t, i, dbg_state, exp_st[i]);
        end
        if (i == 2) begin
          total++;
          if ({pc_write, pc_src} !== {1'b1, exp_src}) begin
            bad++;
            $display("FAIL jmp_exec t%0d: got %b want %b", t, {pc_write, pc_src}, {1'b1, exp_src});
          end
        end
        if (i == 3) begin
          total++;
          if ({reg_write, wb_sel} !== 3'b110) begin
            bad++;
            $display("FAIL jmp_wb t%0d: got %b want 110", t, {reg_write, wb_sel});
          end
        end
        next_cycle();
      end
      total++;
      if (retired_cnt !== 4'(5 + t)) begin
        bad++;
        $display("FAIL jmp_cnt t%0d: got %0d want %0d", t, retired_cnt, 5 + t);
      end
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (i < 2) begin
        if (dbg_state !== 3'(i)) begin
          bad++;
          $display("FAIL ill_state c%0d: got %0d want %0d", i, dbg_state, i);
        end
      end else if ({dbg_state, trap, trap_cause, imem_req} !== {3'd5, 1'b1, 2'd1, 1'b0}) begin
        bad++;
        $display("FAIL ill_trap c%0d: state %0d trap %b cause %0d req %b want 5 1 1 0",
                 i, dbg_state, trap, trap_cause, imem_req);
      end
      next_cycle();
    end
    reset = 1'b1;
    #1;
    total++;
    if ({all_outs, dbg_state} !== '0) begin
      bad++;
      $display("FAIL ill_reset: got %h want 0", {all_outs, dbg_state});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({trap, imem_req} !== 2'b01) begin
      bad++;
      $display("FAIL ill_release: trap %b req %b want 0 1", trap, imem_req);
    end
  endtask

  task automatic test_imem_timeout();
    int exp_st[3];
    exp_st = '{1, 2, 4};
    opcode = OP_U_LUI; imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({dbg_state, imem_req, ir_write} !== {3'd0, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL imto_wait c%0d: state %0d req %b irw %b want 0 1 0", i, dbg_state, imem_req, ir_write);
      end
      next_cycle();
    end
    @(negedge clk);
    total++;
    if ({dbg_state, trap, trap_cause} !== {3'd5, 1'b1, 2'd2}) begin
      bad++;
      $display("FAIL imto_trap: state %0d trap %b cause %0d want 5 1 2", dbg_state, trap, trap_cause);
    end
    apply_reset();
    // Ready arrives exactly on the limit cycle.
    for (int i = 0; i < 5; i++) begin
      imem_ready = (i == 4);
      @(negedge clk);
      total++;
      if ({dbg_state, ir_write} !== {3'd0, (i == 4)}) begin
        bad++;
        $display("FAIL imlim_fetch c%0d: state %0d irw %b want 0 %b", i, dbg_state, ir_write, (i == 4));
      end
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({dbg_state, trap} !== {3'(exp_st[i]), 1'b0}) begin
        bad++;
        $display("FAIL imlim_state c%0d: state %0d trap %b want %0d 0", i, dbg_state, trap, exp_st[i]);
      end
      next_cycle();
    end
    total++;
    if (retired_cnt !== 4'd1) begin
      bad++;
      $display("FAIL imlim_cnt: got %0d want 1", retired_cnt);
    end
  endtask

  task automatic test_dmem_timeout();
    int rw_n = 0;
    opcode = OP_S; imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (dbg_state !== 3'((i < 3) ? i : 3)) begin
        bad++;
        $display("FAIL dmto_state c%0d: got %0d want %0d", i, dbg_state, (i < 3) ? i : 3);
      end
      if (reg_write) rw_n++;
      if (i >= 3) begin
        total++;
        if ({dmem_req, dmem_we, retire} !== 3'b110) begin
          bad++;
          $display("FAIL dmto_mem c%0d: got %b want 110", i, {dmem_req, dmem_we, retire});
        end
      end
      next_cycle();
    end
    @(negedge clk);
    total++;
    if ({dbg_state, trap, trap_cause, retired_cnt} !== {3'd5, 1'b1, 2'd3, 4'd1}) begin
      bad++;
      $display("FAIL dmto_trap: state %0d trap %b cause %0d cnt %0d want 5 1 3 1",
               dbg_state, trap, trap_cause, retired_cnt);
    end
    total++;
    if (rw_n != 0) begin
      bad++;
      $display("FAIL dmto_reg_write: got %0d want 0", rw_n);
    end
    dmem_ready = 1'b1;
    apply_reset();
  endtask

  task automatic test_store_wrap();
    opcode = OP_S; imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int n = 0; n < 17; n++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        total++;
        if (dbg_state !== 3'(i)) begin
          bad++;
          $display("FAIL sw_state n%0d c%0d: got %0d want %0d", n, i, dbg_state, i);
        end
        if (i == 3) begin
          total++;
          if ({dmem_req, dmem_we, retire, reg_write, imem_req} !== 5'b11100) begin
            bad++;
            $display("FAIL sw_mem n%0d: got %b want 11100", n, {dmem_req, dmem_we, retire, reg_write, imem_req});
          end
        end
        next_cycle();
      end
    end
    total++;
    if (retired_cnt !== 4'd1) begin
      bad++;
      $display("FAIL sw_wrap: got %0d want 1", retired_cnt);
    end
  endtask

  task automatic test_reset_mid_mem();
    opcode = OP_S; imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      next_cycle();
    end
    @(negedge clk);
    total++;
    if ({dbg_state, dmem_req} !== {3'd3, 1'b1}) begin
      bad++;
      $display("FAIL mid_mem: state %0d req %b want 3 1", dbg_state, dmem_req);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({all_outs, dbg_state} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got %h want 0", {all_outs, dbg_state});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    dmem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jump();
    test_illegal();
    test_imem_timeout();
    test_dmem_timeout();
    test_store_wrap();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
